// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request unit: default sizes, FSM encoding
// and the board-level assignment of event sources to request lines.
package irq_pkg;

   localparam int NUM_SRC_DEF = 8;
   localparam int CAUSE_W_DEF = $clog2(NUM_SRC_DEF);

   // Source line assignments; lower index means higher priority.
   localparam int NOC_RX  = 0;
   localparam int NOC_TX  = 1;
   localparam int TIMER   = 2;
   localparam int DMA     = 3;
   localparam int UART    = 4;
   localparam int GPIO    = 5;
   localparam int SW_IRQ  = 6;
   localparam int WDOG    = 7;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_REQUEST    = 2'd1,
      ST_IN_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-index finder: reports the highest-priority set bit of req_i.
module irq_priority_encoder #(
   parameter int NUM_SRC = 8,
   parameter int CAUSE_W = 3
) (
   input  logic [NUM_SRC-1:0] req_i,
   output logic [CAUSE_W-1:0] idx_o,
   output logic               valid_o
);

   always_comb begin
      // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
      idx_o   = '0;
      valid_o = 1'b0;
      // Scan downwards so the last hit, the lowest index, is the one that sticks.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = CAUSE_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_request_unit.sv
// Latches rising edges of event sources, picks the highest-priority enabled one and
// runs the request/acknowledge/done handshake with the interrupt controller.
module interrupt_request_unit
   import irq_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int CAUSE_W = CAUSE_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic               interrupt_signal,
   output logic [CAUSE_W-1:0] irq_cause,
   output logic [NUM_SRC-1:0] irq_pending,
   output logic               irq_busy
);

   irq_state_e         state_q;
   logic [NUM_SRC-1:0] src_prev_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;
   logic               armed_q;
   logic               int_q;
   logic               busy_q;
   logic [CAUSE_W-1:0] cause_q;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] eligible;
   logic [CAUSE_W-1:0] winner;
   logic               winner_vld;

   // armed_q stays low for the first clock after reset, so a line already high
   // when reset releases is taken as history rather than as a fresh edge.
   assign rise      = irq_src & ~src_prev_q & {NUM_SRC{armed_q}};
   assign clr       = (state_q == ST_REQUEST && irq_ack) ? (NUM_SRC'(1) << cause_q) : '0;
   assign pending_d = (pending_q & ~clr) | rise;
   assign eligible  = pending_q & irq_mask;

   irq_priority_encoder #(
      .NUM_SRC (NUM_SRC),
      .CAUSE_W (CAUSE_W)
   ) u_prio (
      .req_i   (eligible),
      .idx_o   (winner),
      .valid_o (winner_vld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_prev_q <= '0;
         pending_q  <= '0;
         armed_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         src_prev_q <= irq_src;
         pending_q  <= pending_d;
         armed_q    <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         int_q   <= 1'b0;
         busy_q  <= 1'b0;
         cause_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (winner_vld) begin
                  state_q <= ST_REQUEST;
                  int_q   <= 1'b1;
                  cause_q <= winner;
               end
            end
            ST_REQUEST: begin
               // Acknowledge beats withdrawal when both happen in one cycle.
               if (irq_ack) begin
                  state_q <= ST_IN_SERVICE;
                  int_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (!winner_vld) begin
                  state_q <= ST_IDLE;
                  int_q   <= 1'b0;
               end
            end
            ST_IN_SERVICE: begin
               if (irq_done) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               int_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign interrupt_signal = int_q;
   assign irq_cause        = cause_q;
   assign irq_pending      = pending_q;
   assign irq_busy         = busy_q;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Scenario bench for interrupt_request_unit: expected causes are queued when events
// are driven and popped when the unit raises its request.
module tb_interrupt_request_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irq_src;
   logic [7:0] irq_mask;
   logic       irq_ack;
   logic       irq_done;
   logic       interrupt_signal;
   logic [2:0] irq_cause;
   logic [7:0] irq_pending;
   logic       irq_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   interrupt_request_unit #(
      .NUM_SRC (8),
      .CAUSE_W (3)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .irq_src          (irq_src),
      .irq_mask         (irq_mask),
      .irq_ack          (irq_ack),
      .irq_done         (irq_done),
      .interrupt_signal (interrupt_signal),
      .irq_cause        (irq_cause),
      .irq_pending      (irq_pending),
      .irq_busy         (irq_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a request and compare its cause with the oldest queued expectation.
   task automatic sb_pop(input string name);
      int budget;
      int exp;
      budget = 0;
      while (interrupt_signal !== 1'b1 && budget < 20) begin
         tick();
         budget++;
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: request seen with nothing expected, int=%b cause=%0d", name, interrupt_signal, irq_cause);
      end else begin
         exp = exp_q.pop_front();
         if (interrupt_signal !== 1'b1 || irq_cause !== 3'(exp)) begin
            n_fail++;
            $display("FAIL %s: int=%b cause=%0d, expected int=1 cause=%0d", name, interrupt_signal, irq_cause, exp);
         end
      end
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic pulse_done();
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      irq_src  = '0;
      irq_mask = 8'hFF;
      irq_ack  = 1'b0;
      irq_done = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({interrupt_signal, irq_busy, irq_cause, irq_pending} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_state: int=%b busy=%b cause=%0d pend=%h, expected all 0",
                  interrupt_signal, irq_busy, irq_cause, irq_pending);
      end
      reset = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_single_event();
      irq_src[3] = 1'b1;
      exp_q.push_back(3);
      tick();
      n_checks++;
      if (irq_pending !== 8'h08 || interrupt_signal !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pending: pend=%h int=%b, expected pend=08 int=0", irq_pending, interrupt_signal);
      end
      tick();
      n_checks++;
      if (interrupt_signal !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: int=%b two cycles after edge, expected 1", interrupt_signal);
      end
      sb_pop("single_cause");
      // Source still held high: the level must not re-set pending after the ack clears it.
      pulse_ack();
      tick();
      n_checks++;
      if (irq_pending !== 8'h00 || irq_busy !== 1'b1 || interrupt_signal !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: pend=%h busy=%b int=%b, expected pend=00 busy=1 int=0",
                  irq_pending, irq_busy, interrupt_signal);
      end
      irq_src[3] = 1'b0;
      pulse_ack();
      n_checks++;
      if (irq_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_ack: busy=%b after ack in service, expected 1", irq_busy);
      end
      pulse_done();
      n_checks++;
      if (irq_busy !== 1'b0 || interrupt_signal !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: busy=%b int=%b, expected 0 0", irq_busy, interrupt_signal);
      end
      pulse_done();
      tick();
      n_checks++;
      if (irq_busy !== 1'b0 || interrupt_signal !== 1'b0 || irq_pending !== 8'h00) begin
         n_fail++;
         $display("FAIL stray_done: busy=%b int=%b pend=%h, expected 0 0 00", irq_busy, interrupt_signal, irq_pending);
      end
   endtask

   task automatic test_priority();
      irq_src = 8'h24;
      exp_q.push_back(2);
      exp_q.push_back(5);
      tick();
      irq_src = '0;
      sb_pop("prio_first");
      pulse_ack();
      pulse_done();
      n_checks++;
      if (interrupt_signal !== 1'b0 || irq_pending !== 8'h20) begin
         n_fail++;
         $display("FAIL prio_gap: int=%b pend=%h in gap cycle, expected int=0 pend=20", interrupt_signal, irq_pending);
      end
      tick();
      n_checks++;
      if (interrupt_signal !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_second_timing: int=%b one cycle after idle, expected 1", interrupt_signal);
      end
      sb_pop("prio_second");
      pulse_ack();
      pulse_done();
   endtask

   task automatic test_masking();
      irq_mask   = 8'hBF;
      irq_src[6] = 1'b1;
      tick();
      irq_src = '0;
      n_checks++;
      if (irq_pending !== 8'h40) begin
         n_fail++;
         $display("FAIL mask_pending: pend=%h, expected 40", irq_pending);
      end
      tick();
      tick();
      tick();
      n_checks++;
      if (interrupt_signal !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_blocks: int=%b with source masked, expected 0", interrupt_signal);
      end
      irq_mask = 8'hFF;
      exp_q.push_back(6);
      sb_pop("mask_release");
      pulse_ack();
      pulse_done();
   endtask

   task automatic test_withdrawal();
      irq_src[1] = 1'b1;
      exp_q.push_back(1);
      tick();
      irq_src = '0;
      sb_pop("withdraw_req");
      irq_mask = 8'hFD;
      tick();
      n_checks++;
      if (interrupt_signal !== 1'b0 || irq_pending[1] !== 1'b1 || irq_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL withdraw: int=%b pend=%h busy=%b, expected int=0 pend[1]=1 busy=0",
                  interrupt_signal, irq_pending, irq_busy);
      end
      irq_mask = 8'hFF;
      exp_q.push_back(1);
      sb_pop("withdraw_rerequest");
      // Mask removal and ack in the same cycle: the ack wins.
      irq_mask = 8'hFD;
      pulse_ack();
      n_checks++;
      if (irq_busy !== 1'b1 || irq_pending !== 8'h00) begin
         n_fail++;
         $display("FAIL ack_beats_withdraw: busy=%b pend=%h, expected busy=1 pend=00", irq_busy, irq_pending);
      end
      irq_mask = 8'hFF;
      pulse_done();
   endtask

   task automatic test_collision();
      irq_src[4] = 1'b1;
      exp_q.push_back(4);
      tick();
      irq_src = '0;
      sb_pop("collide_req");
      irq_src[4] = 1'b1;
      pulse_ack();
      irq_src = '0;
      n_checks++;
      if (irq_busy !== 1'b1 || irq_pending !== 8'h10) begin
         n_fail++;
         $display("FAIL collide_set_wins: busy=%b pend=%h, expected busy=1 pend=10", irq_busy, irq_pending);
      end
      exp_q.push_back(4);
      pulse_done();
      sb_pop("collide_rerequest");
      pulse_ack();
      pulse_done();
   endtask

   task automatic test_reset_mid_service();
      irq_src[0] = 1'b1;
      exp_q.push_back(0);
      tick();
      irq_src = '0;
      sb_pop("rst_setup");
      irq_src = 8'h0C;
      pulse_ack();
      irq_src = 8'h08;
      n_checks++;
      if (irq_busy !== 1'b1 || irq_pending !== 8'h0C) begin
         n_fail++;
         $display("FAIL rst_setup_state: busy=%b pend=%h, expected busy=1 pend=0C", irq_busy, irq_pending);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({interrupt_signal, irq_busy, irq_cause, irq_pending} !== 13'd0) begin
         n_fail++;
         $display("FAIL rst_async: int=%b busy=%b cause=%0d pend=%h, expected all 0",
                  interrupt_signal, irq_busy, irq_cause, irq_pending);
      end
      tick();
      tick();
      reset = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (interrupt_signal !== 1'b0 || irq_pending !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_held_src: int=%b pend=%h, expected int=0 pend=00", interrupt_signal, irq_pending);
      end
      irq_src = '0;
      tick();
      irq_src[3] = 1'b1;
      exp_q.push_back(3);
      tick();
      irq_src = '0;
      sb_pop("rst_rearm");
      pulse_ack();
      pulse_done();
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_priority();
      test_masking();
      test_withdrawal();
      test_collision();
      test_reset_mid_service();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expected requests never seen, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
